// File: rtl/truth_table_scanner.sv
// Walks a 3-input block through all eight input combinations and
// captures F into an 8-bit truth table with a complement-rail check.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f,
  input  logic       fn,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic [3:0] ones,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 4'd0;
      x        <= 1'b0;
      y        <= 1'b0;
      z        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= 8'h00;
      ones     <= 4'd0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= 3'd0;
            cnt       <= RELOAD;
            tt        <= 8'h00;
            ones      <= 4'd0;
            mismatch  <= 1'b0;
            busy      <= 1'b1;
            {x, y, z} <= 3'd0;
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt[idx] <= f;
          ones    <= ones + {3'd0, f};
          // Both rails equal means the complement output is broken.
          if (fn == f) begin
            mismatch <= 1'b1;
          end
          if (idx != 3'd7) begin
            idx       <= idx + 3'd1;
            cnt       <= RELOAD;
            state     <= DRIVE;
            {x, y, z} <= idx + 3'd1;
          end else begin
            state     <= DONE;
            busy      <= 1'b0;
            {x, y, z} <= 3'd0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: three scanners (SETTLE 2, 1, 15) driven by a
// behavioural model of F=(x+z)(x'+y') with selectable faults.
module tb_truth_table_scanner;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] f_v;
  logic [2:0] fn_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] mm_v;
  logic [2:0] p0, p1, p2;
  logic [7:0] tt0, tt1, tt2;
  logic [3:0] on0, on1, on2;

  int mode;
  logic fault5;
  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  truth_table_scanner #(.SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .f(f_v[0]), .fn(fn_v[0]),
    .x(p0[2]), .y(p0[1]), .z(p0[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .tt(tt0), .ones(on0), .mismatch(mm_v[0])
  );

  truth_table_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .f(f_v[1]), .fn(fn_v[1]),
    .x(p1[2]), .y(p1[1]), .z(p1[0]),
    .busy(busy_v[1]), .done(done_v[1]),
    .tt(tt1), .ones(on1), .mismatch(mm_v[1])
  );

  truth_table_scanner #(.SETTLE(15)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .f(f_v[2]), .fn(fn_v[2]),
    .x(p2[2]), .y(p2[1]), .z(p2[0]),
    .busy(busy_v[2]), .done(done_v[2]),
    .tt(tt2), .ones(on2), .mismatch(mm_v[2])
  );

  function automatic logic fmodel(logic [2:0] i);
    return (i[2] | i[0]) & (~i[2] | ~i[1]);
  endfunction

  always_comb begin
    f_v  = 3'b000;
    fn_v = 3'b000;
    case (mode)
      1: f_v[0] = 1'b0;
      2: f_v[0] = 1'b1;
      default: f_v[0] = fmodel(p0);
    endcase
    fn_v[0] = ~f_v[0];
    if (fault5 && p0 == 3'd5) fn_v[0] = f_v[0];
    f_v[1]  = fmodel(p1);
    fn_v[1] = ~f_v[1];
    f_v[2]  = fmodel(p2);
    fn_v[2] = ~f_v[2];
  end

  function automatic logic [2:0] xyz_of(int u);
    case (u)
      0: return p0;
      1: return p1;
      default: return p2;
    endcase
  endfunction

  function automatic int settle_of(int u);
    case (u)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then follows the scan; poke re-asserts start mid-scan.
  task automatic run_scan(input int u, input int poke,
                          output int lat, output int seq_err);
    int s;
    int per;
    logic [2:0] e;
    s = settle_of(u);
    per = s + 1;
    seq_err = 0;
    lat = -1;
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k < 8 * per) begin
        e = 3'(k / per);
        if (xyz_of(u) !== e || busy_v[u] !== 1'b1)
          seq_err++;
      end else if (k == 8 * per) begin
        if (xyz_of(u) !== 3'd0 || busy_v[u] !== 1'b0)
          seq_err++;
      end
      if (done_v[u] === 1'b1) begin
        lat = k;
        break;
      end
      start_v[u] = (k == poke) ? 1'b1 : 1'b0;
      tick();
    end
    start_v[u] = 1'b0;
  endtask

  initial begin
    int lat;
    int serr;
    int n;
    int a;
    int b;
    vectors = 0;
    miscompares = 0;
    mode = 0;
    fault5 = 1'b0;
    rst_n = 1'b0;
    start_v = 3'b000;
    tick();
    tick();
    chk("rst_tt", 32'(tt0), 32'h00);
    chk("rst_ones", 32'(on0), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_xyz", 32'(p0), 32'd0);
    chk("rst_mm", 32'(mm_v[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    run_scan(0, -1, lat, serr);
    chk("fn_lat", 32'(lat), 32'd25);
    chk("fn_seq", 32'(serr), 32'd0);
    chk("fn_tt", 32'(tt0), 32'h3A);
    chk("fn_ones", 32'(on0), 32'd4);
    chk("fn_mm", 32'(mm_v[0]), 32'd0);
    tick();
    chk("done_width", 32'(done_v[0]), 32'd0);
    for (int k = 0; k < 8; k++) tick();
    chk("hold_tt", 32'(tt0), 32'h3A);
    chk("hold_ones", 32'(on0), 32'd4);

    mode = 1;
    run_scan(0, -1, lat, serr);
    chk("z_tt", 32'(tt0), 32'h00);
    chk("z_ones", 32'(on0), 32'd0);
    chk("z_mm", 32'(mm_v[0]), 32'd0);
    tick();

    mode = 2;
    run_scan(0, -1, lat, serr);
    chk("o_tt", 32'(tt0), 32'hFF);
    chk("o_ones", 32'(on0), 32'd8);
    chk("o_mm", 32'(mm_v[0]), 32'd0);
    tick();

    mode = 0;
    fault5 = 1'b1;
    run_scan(0, -1, lat, serr);
    chk("f5_mm", 32'(mm_v[0]), 32'd1);
    chk("f5_tt", 32'(tt0), 32'h3A);
    fault5 = 1'b0;
    tick();

    run_scan(0, 6, lat, serr);
    chk("ign_lat", 32'(lat), 32'd25);
    chk("ign_mm", 32'(mm_v[0]), 32'd0);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done_v[0] === 1'b1) n++;
    end
    chk("ign_extra", 32'(n), 32'd0);
    chk("ign_busy", 32'(busy_v[0]), 32'd0);

    a = -1;
    b = -1;
    start_v[0] = 1'b1;
    for (int k = 0; k < 200 && b < 0; k++) begin
      tick();
      if (done_v[0] === 1'b1) begin
        if (a < 0) a = k;
        else b = k;
      end
    end
    start_v[0] = 1'b0;
    chk("b2b_gap", 32'(b - a), 32'd26);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    rst_n = 1'b0;
    start_v[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    start_v[0] = 1'b0;
    chk("rst_prio", 32'(busy_v[0]), 32'd0);
    tick();

    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 50 && p0 !== 3'd3; k++) begin
      tick();
      n++;
    end
    chk("mid_reach3", 32'(p0), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_tt", 32'(tt0), 32'h00);
    chk("mid_ones", 32'(on0), 32'd0);
    chk("mid_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_xyz", 32'(p0), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_v[0] === 1'b1) n++;
      tick();
    end
    chk("mid_nodone", 32'(n), 32'd0);
    run_scan(0, -1, lat, serr);
    chk("re_lat", 32'(lat), 32'd25);
    chk("re_tt", 32'(tt0), 32'h3A);
    tick();

    run_scan(1, -1, lat, serr);
    chk("s1_lat", 32'(lat), 32'd17);
    chk("s1_seq", 32'(serr), 32'd0);
    chk("s1_tt", 32'(tt1), 32'h3A);
    tick();

    run_scan(2, -1, lat, serr);
    chk("s15_lat", 32'(lat), 32'd129);
    chk("s15_seq", 32'(serr), 32'd0);
    chk("s15_tt", 32'(tt2), 32'h3A);
    chk("s15_ones", 32'(on2), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 2, range 1..15: cycles each input combination is held before its output is sampled.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one full scan; sampled only in IDLE.
REQ-005 SHALL have port f  input  1  function output F from the gate-level block under scan.
REQ-006 SHALL have port fn  input  1  complement output Fn from the block under scan.
REQ-007 SHALL have port x  output  1  drive to input x; MSB of the combination index.
REQ-008 SHALL have port y  output  1  drive to input y; middle bit of the index.
REQ-009 SHALL have port z  output  1  drive to input z; LSB of the index.
REQ-010 SHALL have port busy  output  1  high while a scan is in progress (DRIVE or SAMPLE).
REQ-011 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-012 SHALL have port tt  output  8  captured truth table; tt[i] = F at index i = {x,y,z}.
REQ-013 SHALL have port ones  output  4  count of minterms (set bits in tt), range 0..8.
REQ-014 SHALL have port mismatch  output  1  high if Fn != ~F at any sampled index.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE, plus a 3-bit index idx and a 4-bit settle counter cnt.
REQ-016 In IDLE with start=1, SHALL accept the request: go to DRIVE; set idx=0, cnt=SETTLE-1; clear tt, ones and mismatch.
REQ-017 In IDLE, SHALL hold x,y,z at 0.
REQ-018 In DRIVE and SAMPLE, SHALL drive {x,y,z} = idx as registered outputs.
REQ-019 In DRIVE, SHALL decrement cnt each cycle while cnt != 0; when cnt == 0, SHALL go to SAMPLE.
REQ-020 Each index SHALL therefore be held for exactly SETTLE DRIVE cycles followed by 1 SAMPLE cycle.
REQ-021 In SAMPLE, SHALL set tt[idx] = f.
REQ-022 In SAMPLE, SHALL increment ones when f=1.
REQ-023 In SAMPLE, SHALL set mismatch when fn == f; mismatch is sticky within a scan.
REQ-024 In SAMPLE with idx != 7, SHALL set idx = idx+1, reload cnt = SETTLE-1 and go to DRIVE.
REQ-025 In SAMPLE with idx == 7, SHALL go to DONE; idx SHALL NOT wrap into a new scan.
REQ-026 In DONE, SHALL assert done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-027 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-028 done SHALL rise exactly 8*(SETTLE+1)+1 cycles after the clock edge that accepts start.
REQ-029 start asserted in DRIVE, SAMPLE or DONE SHALL be ignored; it is not queued.
REQ-030 start held high continuously SHALL begin a new scan on the cycle after DONE (back-to-back scans).
REQ-031 tt, ones and mismatch SHALL hold their values from DONE until the next accepted start.
REQ-032 ones SHALL be exactly 4 bits wide; 8 SHALL be representable without overflow.

Reset
REQ-033 On a clk edge with rst_n=0, SHALL set state=IDLE, idx=0, cnt=0, x=y=z=0, busy=0, done=0, tt=8'h00, ones=0 and mismatch=0.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no done pulse; the partial results SHALL be cleared.
REQ-035 Reset SHALL take priority over start in the same cycle.

Verification
REQ-036 Scan of a block with F=(x+z)(x'+y') and Fn=~F, SETTLE=2, start pulsed once -> done 25 cycles later; tt=8'h3A, ones=4, mismatch=0.
REQ-037 Scan with f tied 0 and fn tied 1 -> tt=8'h00, ones=0, mismatch=0; with f tied 1 and fn tied 0 -> tt=8'hFF, ones=8, mismatch=0.
REQ-038 Scan with fn forced equal to f at index 5 only -> mismatch=1, with tt unaffected.
REQ-039 Reset pulsed at index 3 mid-scan -> next cycle all outputs at reset values, no done pulse; a new start then gives a full scan.
REQ-040 start pulsed again during busy -> ignored, exactly one done pulse; start held high -> done pulses spaced 8*(SETTLE+1)+2 cycles apart.
REQ-041 SETTLE=1 and SETTLE=15 -> each {x,y,z} value held for SETTLE+1 cycles, indices visited in order 0..7.
